bcd_producto: RTL and testbench

Sequential signed-binary to BCD converter placed directly downstream of the Booth multiplier `mult`. It captures the multiplier's two's-complement product on the rising edge of the multiplier's `fin` flag, converts the magnitude iteratively with shift-add-3, one bit per clock. It then presents sign plus decimal digits for display, with a one-cycle `listo` pulse when the result is valid.

---
 rtl/mult_pkg.sv | 17 +
 rtl/bcd_producto_if.sv | 29 ++
 rtl/bcd_producto_add3.sv | 13 +
 rtl/bcd_producto.sv | 109 ++++++++++
 tb/tb_bcd_producto.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared constants for the Booth multiplier and its BCD output stage.
//   PRODUCTO_W  : width of the multiplier product (two's complement)
//   estado_t    : state encoding of the BCD converter FSM
//   UMBRAL_ADD3 : digit value from which shift-add-3 adds 3 before shifting
package mult_pkg;

  localparam int PRODUCTO_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } estado_t;

  localparam logic [3:0] UMBRAL_ADD3 = 4'd5;

endpackage

// File: rtl/bcd_producto_if.sv
// Bus between the multiplier side and the BCD converter.
//   producto : two's-complement product (W bits)
//   fin      : multiplier done flag, rising edge starts a conversion
//   signo    : 1 = result negative
//   digitos  : BCD magnitude, units digit in [3:0]
//   listo    : one-cycle pulse, signo/digitos just updated
//   ocupado  : conversion in progress
// master drives producto/fin; slave (the converter) drives the results.
interface bcd_producto_if #(
  parameter int W  = 8,
  parameter int ND = 3
);
  logic signed [W-1:0]    producto;
  logic                   fin;
  logic                   signo;
  logic        [4*ND-1:0] digitos;
  logic                   listo;
  logic                   ocupado;

  modport master (
    output producto, fin,
    input  signo, digitos, listo, ocupado
  );

  modport slave (
    input  producto, fin,
    output signo, digitos, listo, ocupado
  );
endinterface

// File: rtl/bcd_producto_add3.sv
// One BCD digit correction step of shift-add-3.
//   din  : current BCD digit
//   dout : din + 3 when din >= 5, otherwise din
module add3_digit
  import mult_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= UMBRAL_ADD3) ? din + 4'd3 : din;

endmodule

// File: rtl/bcd_producto.sv
// Signed binary to BCD converter for the multiplier product.
// Captures producto on a rising edge of fin, converts the magnitude with
// shift-add-3 one bit per clock and presents sign plus ND BCD digits,
// pulsing listo for one cycle when the new result is valid.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bcd_producto_if (producto, fin in; signo,
//           digitos, listo, ocupado out)
module bcd_producto
  import mult_pkg::*;
#(
  parameter int W  = PRODUCTO_W,
  parameter int ND = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  bcd_producto_if.slave  bus
);

  localparam int CW = $clog2(W + 1);
  localparam int SW = 4 * ND + W;

  // Magnitude as W-bit unsigned; the most negative value maps to 2^(W-1).
  function automatic logic [W-1:0] magnitud(input logic [W-1:0] p);
    return p[W-1] ? (~p + W'(1)) : p;
  endfunction

  estado_t          estado, estado_sig;
  logic             fin_q;
  logic [CW-1:0]    cnt;
  logic [SW-1:0]    sr;
  logic             signo_r;
  logic [4*ND-1:0]  bcd_aj;
  logic [SW-1:0]    sr_sh;
  logic             subida;
  logic             carga;
  logic             paso;
  logic             ultimo;

  assign subida = bus.fin & ~fin_q;
  assign ultimo = (cnt == CW'(W - 1));

  for (genvar g = 0; g < ND; g++) begin : g_add3
    add3_digit u_add3 (
      .din  (sr[W + 4*g +: 4]),
      .dout (bcd_aj[4*g +: 4])
    );
  end

  // Corrected digits and remaining magnitude shift left together.
  assign sr_sh = {bcd_aj, sr[W-1:0]} << 1;

  always_comb begin
    estado_sig = estado;
    carga      = 1'b0;
    paso       = 1'b0;
    unique case (estado)
      IDLE, DONE: begin
        if (subida) begin
          carga      = 1'b1;
          estado_sig = CONV;
        end else begin
          estado_sig = IDLE;
        end
      end
      CONV: begin
        paso = 1'b1;
        if (ultimo) estado_sig = DONE;
      end
      default: estado_sig = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= IDLE;
      fin_q  <= 1'b0;
    end else begin
      estado <= estado_sig;
      fin_q  <= bus.fin;
    end
  end

  // Capture / iterate / publish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      sr          <= '0;
      signo_r     <= 1'b0;
      bus.signo   <= 1'b0;
      bus.digitos <= '0;
    end else if (carga) begin
      cnt     <= '0;
      sr      <= {{(4*ND){1'b0}}, magnitud(bus.producto)};
      signo_r <= bus.producto[W-1];
    end else if (paso) begin
      cnt <= cnt + CW'(1);
      sr  <= sr_sh;
      if (ultimo) begin
        bus.digitos <= sr_sh[SW-1:W];
        bus.signo   <= signo_r;
      end
    end
  end

  assign bus.listo   = (estado == DONE);
  assign bus.ocupado = (estado == CONV);

endmodule

// File: tb/tb_bcd_producto.sv
module tb_bcd_producto;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  bcd_producto_if #(.W(8), .ND(3)) bus ();

  bcd_producto #(.W(8), .ND(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  prod;
    logic        exp_signo;
    logic [11:0] exp_dig;
  } vec_t;

  vec_t tabla [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Single rise of fin with product p; checks full timing and result.
  task automatic convertir(input logic [7:0] p, input logic es, input logic [11:0] ed);
    @(negedge clk);
    bus.producto = p;
    bus.fin      = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        bus.fin      = 1'b0;
        bus.producto = 8'h55;  // must not disturb the captured value
      end
      if (i <= 8) begin
        chk("ocupado_conv", 32'(bus.ocupado), 32'd1);
        chk("listo_conv", 32'(bus.listo), 32'd0);
      end else if (i == 9) begin
        chk("listo_done", 32'(bus.listo), 32'd1);
        chk("ocupado_done", 32'(bus.ocupado), 32'd0);
        chk("signo", 32'(bus.signo), 32'(es));
        chk("digitos", 32'(bus.digitos), 32'(ed));
      end else begin
        chk("listo_after", 32'(bus.listo), 32'd0);
        chk("digitos_hold", 32'(bus.digitos), 32'(ed));
      end
    end
  endtask

  initial begin
    int pulsos;
    total = 0;
    bad   = 0;

    tabla[0] = '{8'd6,   1'b0, 12'h006};
    tabla[1] = '{8'hC8,  1'b1, 12'h056};
    tabla[2] = '{8'h80,  1'b1, 12'h128};
    tabla[3] = '{8'h7F,  1'b0, 12'h127};
    tabla[4] = '{8'h00,  1'b0, 12'h000};
    tabla[5] = '{8'hF7,  1'b1, 12'h009};
    tabla[6] = '{8'd99,  1'b0, 12'h099};
    tabla[7] = '{8'h9C,  1'b1, 12'h100};

    rst_n        = 1'b0;
    bus.fin      = 1'b0;
    bus.producto = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_signo", 32'(bus.signo), 32'd0);
    chk("rst_digitos", 32'(bus.digitos), 32'd0);
    chk("rst_listo", 32'(bus.listo), 32'd0);
    chk("rst_ocupado", 32'(bus.ocupado), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int k = 0; k < 8; k++)
      convertir(tabla[k].prod, tabla[k].exp_signo, tabla[k].exp_dig);

    // fin held high 30 cycles: exactly one result
    @(negedge clk);
    bus.producto = 8'd40;
    bus.fin      = 1'b1;
    pulsos       = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.listo) pulsos++;
      if (i == 9) chk("held_digitos", 32'(bus.digitos), 32'h040);
      if (i == 30) bus.fin = 1'b0;
    end
    chk("held_pulses", 32'(pulsos), 32'd1);

    // second rise during CONV is dropped
    @(negedge clk);
    bus.producto = 8'd6;
    bus.fin      = 1'b1;
    pulsos       = 0;
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk); #1;
      if (bus.listo) pulsos++;
      if (i == 1) bus.fin = 1'b0;
      if (i == 3) begin
        bus.fin      = 1'b1;
        bus.producto = 8'h7F;
      end
      if (i == 4) bus.fin = 1'b0;
      if (i == 9) begin
        chk("ign_listo", 32'(bus.listo), 32'd1);
        chk("ign_digitos", 32'(bus.digitos), 32'h006);
      end
    end
    chk("ign_pulses", 32'(pulsos), 32'd1);

    // back-to-back: second rise in the DONE cycle
    @(negedge clk);
    bus.producto = 8'd40;
    bus.fin      = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      @(posedge clk); #1;
      if (i == 1) bus.fin = 1'b0;
      if (i == 9) begin
        chk("b2b_listo1", 32'(bus.listo), 32'd1);
        chk("b2b_dig1", 32'(bus.digitos), 32'h040);
        @(negedge clk);
        bus.producto = 8'hF7;
        bus.fin      = 1'b1;
      end
      if (i == 10) bus.fin = 1'b0;
      if (i >= 10 && i <= 17) begin
        chk("b2b_ocupado", 32'(bus.ocupado), 32'd1);
        chk("b2b_listo_mid", 32'(bus.listo), 32'd0);
        chk("b2b_hold_dig", 32'(bus.digitos), 32'h040);
        chk("b2b_hold_signo", 32'(bus.signo), 32'd0);
      end
      if (i == 18) begin
        chk("b2b_listo2", 32'(bus.listo), 32'd1);
        chk("b2b_signo2", 32'(bus.signo), 32'd1);
        chk("b2b_dig2", 32'(bus.digitos), 32'h009);
      end
      if (i == 19) chk("b2b_listo_end", 32'(bus.listo), 32'd0);
    end

    // reset mid-conversion, fin still high at release
    @(negedge clk);
    bus.producto = 8'h7F;
    bus.fin      = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_signo", 32'(bus.signo), 32'd0);
    chk("midrst_digitos", 32'(bus.digitos), 32'd0);
    chk("midrst_ocupado", 32'(bus.ocupado), 32'd0);
    chk("midrst_listo", 32'(bus.listo), 32'd0);
    pulsos = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.listo) pulsos++;
    end
    chk("midrst_nolisto", 32'(pulsos), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i <= 8) chk("restart_ocupado", 32'(bus.ocupado), 32'd1);
      if (i == 9) begin
        chk("restart_listo", 32'(bus.listo), 32'd1);
        chk("restart_signo", 32'(bus.signo), 32'd0);
        chk("restart_dig", 32'(bus.digitos), 32'h127);
        bus.fin = 1'b0;
      end
      if (i == 10) chk("restart_listo_end", 32'(bus.listo), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
